// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand capture with optional forwarding, ALU select decode,
// hold/stall/flush handling and a saturating bubble counter. Forwarding: ID_EX_FORWARD_EN.
module id_ex_stage #(
    parameter int unsigned bits  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [bits-1:0]  i_rs_data,
    input  logic [bits-1:0]  i_rt_data,
    input  logic [bits-1:0]  i_imm,
    input  logic [4:0]       i_shamt,
    input  logic [4:0]       i_rs_addr,
    input  logic [4:0]       i_rt_addr,
    input  logic [4:0]       i_rd_addr,
    input  logic [1:0]       i_alu_op,
    input  logic [5:0]       i_funct,
    input  logic             i_alu_src,
    input  logic             i_reg_write,
    input  logic             i_hold,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             i_exmem_we,
    input  logic [4:0]       i_exmem_rd,
    input  logic [bits-1:0]  i_exmem_data,
    input  logic             i_memwb_we,
    input  logic [4:0]       i_memwb_rd,
    input  logic [bits-1:0]  i_memwb_data,
    output logic             o_valid,
    output logic [bits-1:0]  o_A,
    output logic [bits-1:0]  o_B,
    output logic [3:0]       o_select,
    output logic [4:0]       o_rd_addr,
    output logic             o_reg_write,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_bubbles
);

    localparam logic [1:0] OpAdd   = 2'b00;
    localparam logic [1:0] OpSub   = 2'b01;
    localparam logic [1:0] OpRtype = 2'b10;
    localparam logic [1:0] OpOri   = 2'b11;

    localparam logic [3:0] SelAnd = 4'b0000;
    localparam logic [3:0] SelOr  = 4'b0001;
    localparam logic [3:0] SelAdd = 4'b0010;
    localparam logic [3:0] SelSra = 4'b0011;
    localparam logic [3:0] SelSrl = 4'b0100;
    localparam logic [3:0] SelNor = 4'b0101;
    localparam logic [3:0] SelSub = 4'b0110;
    localparam logic [3:0] SelNop = 4'b0111;
    localparam logic [3:0] SelXor = 4'b1001;
    localparam logic [3:0] SelSll = 4'b1011;

    logic [bits-1:0] fwd_rs, fwd_rt;

`ifdef ID_EX_FORWARD_EN
    // EX/MEM is younger than MEM/WB, so it wins when both match; r0 is never forwarded.
    always_comb begin
        fwd_rs = i_rs_data;
        if (i_exmem_we && (i_exmem_rd == i_rs_addr) && (i_rs_addr != 5'd0)) begin
            fwd_rs = i_exmem_data;
        end else if (i_memwb_we && (i_memwb_rd == i_rs_addr) && (i_rs_addr != 5'd0)) begin
            fwd_rs = i_memwb_data;
        end
    end

    always_comb begin
        fwd_rt = i_rt_data;
        if (i_exmem_we && (i_exmem_rd == i_rt_addr) && (i_rt_addr != 5'd0)) begin
            fwd_rt = i_exmem_data;
        end else if (i_memwb_we && (i_memwb_rd == i_rt_addr) && (i_rt_addr != 5'd0)) begin
            fwd_rt = i_memwb_data;
        end
    end
`else
    assign fwd_rs = i_rs_data;
    assign fwd_rt = i_rt_data;

    logic unused_fwd;
    assign unused_fwd = ^{i_rs_addr, i_rt_addr, i_exmem_we, i_exmem_rd, i_exmem_data,
                          i_memwb_we, i_memwb_rd, i_memwb_data};
`endif

    logic [3:0] dec_sel;
    logic       dec_illegal;
    logic       dec_shift;

    always_comb begin
        dec_sel     = SelNop;
        dec_illegal = 1'b0;
        dec_shift   = 1'b0;
        unique case (i_alu_op)
            OpAdd: dec_sel = SelAdd;
            OpSub: dec_sel = SelSub;
            OpOri: dec_sel = SelOr;
            OpRtype: begin
                case (i_funct)
                    6'b100100:            dec_sel = SelAnd;
                    6'b100101:            dec_sel = SelOr;
                    6'b100000, 6'b100001: dec_sel = SelAdd;
                    6'b100010, 6'b100011: dec_sel = SelSub;
                    6'b100111:            dec_sel = SelNor;
                    6'b100110:            dec_sel = SelXor;
                    6'b000011: begin
                        dec_sel   = SelSra;
                        dec_shift = 1'b1;
                    end
                    6'b000010: begin
                        dec_sel   = SelSrl;
                        dec_shift = 1'b1;
                    end
                    6'b000000: begin
                        dec_sel   = SelSll;
                        dec_shift = 1'b1;
                    end
                    default: begin
                        dec_sel     = SelNop;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: dec_sel = SelNop;
        endcase
    end

    logic [bits-1:0] op_a, op_b;

    // Shifts operate on rt with the shift amount as the second operand.
    always_comb begin
        if (dec_shift) begin
            op_a = fwd_rt;
            op_b = bits'(i_shamt);
        end else begin
            op_a = fwd_rs;
            op_b = i_alu_src ? i_imm : fwd_rt;
        end
    end

    logic             valid_q, valid_d;
    logic [bits-1:0]  a_q, a_d;
    logic [bits-1:0]  b_q, b_d;
    logic [3:0]       sel_q, sel_d;
    logic [4:0]       rd_q, rd_d;
    logic             rw_q, rw_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] bub_q, bub_d;

    logic load_bubble, load_insn;
    assign load_bubble = i_flush | (i_stall & ~i_hold);
    assign load_insn   = ~i_flush & ~i_hold & ~i_stall;

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        ill_d   = ill_q;
        bub_d   = bub_q;
        if (load_bubble) begin
            valid_d = 1'b0;
            a_d     = '0;
            b_d     = '0;
            sel_d   = SelNop;
            rd_d    = 5'd0;
            rw_d    = 1'b0;
            ill_d   = 1'b0;
            if (bub_q != {CNT_W{1'b1}}) begin
                bub_d = bub_q + CNT_W'(1);
            end
        end else if (load_insn) begin
            valid_d = i_valid;
            a_d     = op_a;
            b_d     = op_b;
            sel_d   = dec_sel;
            rd_d    = i_rd_addr;
            rw_d    = i_valid & i_reg_write & ~dec_illegal;
            ill_d   = dec_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= SelNop;
            rd_q    <= 5'd0;
            rw_q    <= 1'b0;
            ill_q   <= 1'b0;
            bub_q   <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            ill_q   <= ill_d;
            bub_q   <= bub_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_A         = a_q;
    assign o_B         = b_q;
    assign o_select    = sel_q;
    assign o_rd_addr   = rd_q;
    assign o_reg_write = rw_q;
    assign o_illegal   = ill_q;
    assign o_bubbles   = bub_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the stage.
module tb_id_ex_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       i_valid;
    logic [7:0] i_rs_data, i_rt_data, i_imm;
    logic [4:0] i_shamt, i_rs_addr, i_rt_addr, i_rd_addr;
    logic [1:0] i_alu_op;
    logic [5:0] i_funct;
    logic       i_alu_src, i_reg_write, i_hold, i_stall, i_flush;
    logic       i_exmem_we, i_memwb_we;
    logic [4:0] i_exmem_rd, i_memwb_rd;
    logic [7:0] i_exmem_data, i_memwb_data;

    logic        o_valid, o_reg_write, o_illegal;
    logic [7:0]  o_A, o_B;
    logic [3:0]  o_select;
    logic [4:0]  o_rd_addr;
    logic [15:0] o_bubbles;

    logic       s_valid, s_reg_write, s_illegal;
    logic [7:0] s_A, s_B;
    logic [3:0] s_select;
    logic [4:0] s_rd_addr;
    logic [1:0] s_bubbles;

    id_ex_stage #(.bits(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_rs_data(i_rs_data),
        .i_rt_data(i_rt_data), .i_imm(i_imm), .i_shamt(i_shamt), .i_rs_addr(i_rs_addr),
        .i_rt_addr(i_rt_addr), .i_rd_addr(i_rd_addr), .i_alu_op(i_alu_op), .i_funct(i_funct),
        .i_alu_src(i_alu_src), .i_reg_write(i_reg_write), .i_hold(i_hold), .i_stall(i_stall),
        .i_flush(i_flush), .i_exmem_we(i_exmem_we), .i_exmem_rd(i_exmem_rd),
        .i_exmem_data(i_exmem_data), .i_memwb_we(i_memwb_we), .i_memwb_rd(i_memwb_rd),
        .i_memwb_data(i_memwb_data), .o_valid(o_valid), .o_A(o_A), .o_B(o_B),
        .o_select(o_select), .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write),
        .o_illegal(o_illegal), .o_bubbles(o_bubbles)
    );

    id_ex_stage #(.bits(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_rs_data(i_rs_data),
        .i_rt_data(i_rt_data), .i_imm(i_imm), .i_shamt(i_shamt), .i_rs_addr(i_rs_addr),
        .i_rt_addr(i_rt_addr), .i_rd_addr(i_rd_addr), .i_alu_op(i_alu_op), .i_funct(i_funct),
        .i_alu_src(i_alu_src), .i_reg_write(i_reg_write), .i_hold(i_hold), .i_stall(i_stall),
        .i_flush(i_flush), .i_exmem_we(i_exmem_we), .i_exmem_rd(i_exmem_rd),
        .i_exmem_data(i_exmem_data), .i_memwb_we(i_memwb_we), .i_memwb_rd(i_memwb_rd),
        .i_memwb_data(i_memwb_data), .o_valid(s_valid), .o_A(s_A), .o_B(s_B),
        .o_select(s_select), .o_rd_addr(s_rd_addr), .o_reg_write(s_reg_write),
        .o_illegal(s_illegal), .o_bubbles(s_bubbles)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the registered outputs.
    logic        m_valid, m_rw, m_ill;
    logic [7:0]  m_a, m_b;
    logic [3:0]  m_sel;
    logic [4:0]  m_rd;
    int unsigned m_bub, m_bub_s;

    function automatic logic [7:0] ref_fwd(input logic [4:0] addr, input logic [7:0] data);
`ifdef ID_EX_FORWARD_EN
        if (addr != 5'd0 && i_exmem_we && i_exmem_rd == addr) return i_exmem_data;
        if (addr != 5'd0 && i_memwb_we && i_memwb_rd == addr) return i_memwb_data;
`endif
        return data;
    endfunction

    task automatic ref_decode(input logic [1:0] op, input logic [5:0] f,
                              output logic [3:0] sel, output logic ill, output logic shift);
        ill = 1'b0;
        shift = 1'b0;
        case (op)
            2'b00: sel = 4'b0010;
            2'b01: sel = 4'b0110;
            2'b11: sel = 4'b0001;
            default: begin
                case (f)
                    6'b100100: sel = 4'b0000;
                    6'b100101: sel = 4'b0001;
                    6'b100000, 6'b100001: sel = 4'b0010;
                    6'b000011: begin sel = 4'b0011; shift = 1'b1; end
                    6'b000010: begin sel = 4'b0100; shift = 1'b1; end
                    6'b100111: sel = 4'b0101;
                    6'b100010, 6'b100011: sel = 4'b0110;
                    6'b100110: sel = 4'b1001;
                    6'b000000: begin sel = 4'b1011; shift = 1'b1; end
                    default: begin sel = 4'b0111; ill = 1'b1; end
                endcase
            end
        endcase
    endtask

    task automatic model_reset();
        m_valid = 0; m_a = 0; m_b = 0; m_sel = 4'b0111; m_rd = 0; m_rw = 0; m_ill = 0;
        m_bub = 0; m_bub_s = 0;
    endtask

    task automatic model_edge();
        logic [3:0] sel;
        logic ill, shift;
        if (i_flush || (i_stall && !i_hold)) begin
            m_valid = 0; m_a = 0; m_b = 0; m_sel = 4'b0111; m_rd = 0; m_rw = 0; m_ill = 0;
            if (m_bub < 65535) m_bub++;
            if (m_bub_s < 3) m_bub_s++;
        end else if (!i_hold) begin
            ref_decode(i_alu_op, i_funct, sel, ill, shift);
            m_a     = shift ? ref_fwd(i_rt_addr, i_rt_data) : ref_fwd(i_rs_addr, i_rs_data);
            m_b     = shift ? {3'b000, i_shamt}
                            : (i_alu_src ? i_imm : ref_fwd(i_rt_addr, i_rt_data));
            m_sel   = sel;
            m_ill   = ill;
            m_valid = i_valid;
            m_rd    = i_rd_addr;
            m_rw    = i_valid && i_reg_write && !ill;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_valid = 0; i_rs_data = 0; i_rt_data = 0; i_imm = 0; i_shamt = 0;
        i_rs_addr = 0; i_rt_addr = 0; i_rd_addr = 0; i_alu_op = 0; i_funct = 0;
        i_alu_src = 0; i_reg_write = 0; i_hold = 0; i_stall = 0; i_flush = 0;
        i_exmem_we = 0; i_exmem_rd = 0; i_exmem_data = 0;
        i_memwb_we = 0; i_memwb_rd = 0; i_memwb_data = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        n_cmp++;
        if ({o_valid, o_A, o_B, o_rd_addr, o_reg_write, o_illegal} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_zero got v=%0b A=%h B=%h rd=%0d rw=%0b ill=%0b expected all 0",
                     o_valid, o_A, o_B, o_rd_addr, o_reg_write, o_illegal);
        end
        n_cmp++;
        if (o_select !== 4'b0111) begin
            n_err++;
            $display("FAIL reset_select got %b expected 0111", o_select);
        end
        n_cmp++;
        if (o_bubbles !== 16'd0) begin
            n_err++;
            $display("FAIL reset_bubbles got %0d expected 0", o_bubbles);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_load();
        idle();
        i_valid = 1; i_alu_op = 2'b10; i_funct = 6'b100010; i_rs_addr = 1; i_rt_addr = 2;
        i_rs_data = 8'd5; i_rt_data = 8'd3; i_rd_addr = 5'd7; i_reg_write = 1;
        tick();
        n_cmp++;
        if (o_A !== 8'd5 || o_B !== 8'd3) begin
            n_err++;
            $display("FAIL load_operands got A=%0d B=%0d expected A=5 B=3", o_A, o_B);
        end
        n_cmp++;
        if (o_select !== 4'b0110 || o_valid !== 1'b1) begin
            n_err++;
            $display("FAIL load_sel_valid got sel=%b v=%0b expected 0110 1", o_select, o_valid);
        end
        n_cmp++;
        if (o_rd_addr !== 5'd7 || o_reg_write !== 1'b1) begin
            n_err++;
            $display("FAIL load_rd got rd=%0d rw=%0b expected 7 1", o_rd_addr, o_reg_write);
        end
    endtask

    task automatic test_forward();
        logic [7:0] exp_ab;
        idle();
        i_valid = 1; i_alu_op = 2'b00; i_rs_addr = 4; i_rt_addr = 4;
        i_rs_data = 8'h11; i_rt_data = 8'h11;
        i_exmem_we = 1; i_exmem_rd = 4; i_exmem_data = 8'd9;
        i_memwb_we = 1; i_memwb_rd = 4; i_memwb_data = 8'd7;
`ifdef ID_EX_FORWARD_EN
        exp_ab = 8'd9;
`else
        exp_ab = 8'h11;
`endif
        tick();
        n_cmp++;
        if (o_A !== exp_ab || o_B !== exp_ab) begin
            n_err++;
            $display("FAIL fwd_exmem got A=%h B=%h expected %h", o_A, o_B, exp_ab);
        end
        i_exmem_we = 0;
`ifdef ID_EX_FORWARD_EN
        exp_ab = 8'd7;
`endif
        tick();
        n_cmp++;
        if (o_A !== exp_ab || o_B !== exp_ab) begin
            n_err++;
            $display("FAIL fwd_memwb got A=%h B=%h expected %h", o_A, o_B, exp_ab);
        end
        i_exmem_we = 1; i_rs_addr = 0; i_rt_addr = 0; i_exmem_rd = 0; i_memwb_rd = 0;
        i_rs_data = 8'h21; i_rt_data = 8'h42;
        tick();
        n_cmp++;
        if (o_A !== 8'h21 || o_B !== 8'h42) begin
            n_err++;
            $display("FAIL fwd_r0 got A=%h B=%h expected 21 42", o_A, o_B);
        end
    endtask

    task automatic test_shift();
        idle();
        i_valid = 1; i_alu_op = 2'b10; i_funct = 6'b000011; i_rt_addr = 5;
        i_rt_data = 8'hF0; i_rs_data = 8'h3C; i_shamt = 5'd2; i_imm = 8'hAA; i_alu_src = 1;
        tick();
        n_cmp++;
        if (o_A !== 8'hF0 || o_B !== 8'h02 || o_select !== 4'b0011) begin
            n_err++;
            $display("FAIL shift_sra got A=%h B=%h sel=%b expected F0 02 0011",
                     o_A, o_B, o_select);
        end
    endtask

    task automatic test_priority();
        int unsigned bub0;
        bub0 = m_bub;
        i_hold = 1; i_stall = 1; i_rs_data = 8'h77; i_rt_data = 8'h66; i_funct = 6'b100100;
        tick();
        n_cmp++;
        if (o_A !== 8'hF0 || o_B !== 8'h02 || o_select !== 4'b0011 || o_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_stall_frozen got A=%h B=%h sel=%b v=%0b expected F0 02 0011 1",
                     o_A, o_B, o_select, o_valid);
        end
        n_cmp++;
        if (o_bubbles !== 16'(bub0)) begin
            n_err++;
            $display("FAIL hold_stall_count got %0d expected %0d", o_bubbles, bub0);
        end
        i_stall = 0; i_flush = 1;
        tick();
        n_cmp++;
        if (o_valid !== 1'b0 || o_A !== 8'h00 || o_select !== 4'b0111 || o_reg_write !== 1'b0)
        begin
            n_err++;
            $display("FAIL flush_hold_bubble got v=%0b A=%h sel=%b rw=%0b expected 0 00 0111 0",
                     o_valid, o_A, o_select, o_reg_write);
        end
        n_cmp++;
        if (o_bubbles !== 16'(bub0 + 1)) begin
            n_err++;
            $display("FAIL flush_hold_count got %0d expected %0d", o_bubbles, bub0 + 1);
        end
    endtask

    task automatic test_illegal();
        idle();
        i_valid = 1; i_reg_write = 1; i_alu_op = 2'b10; i_funct = 6'b111111; i_rd_addr = 5'd9;
        tick();
        n_cmp++;
        if (o_select !== 4'b0111 || o_illegal !== 1'b1 || o_reg_write !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_funct got sel=%b ill=%0b rw=%0b expected 0111 1 0",
                     o_select, o_illegal, o_reg_write);
        end
    endtask

    task automatic test_saturation();
        idle();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        i_stall = 1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (s_bubbles !== 2'd3) begin
            n_err++;
            $display("FAIL sat_cnt2 got %0d expected 3", s_bubbles);
        end
        n_cmp++;
        if (o_bubbles !== 16'd5) begin
            n_err++;
            $display("FAIL cnt16_five got %0d expected 5", o_bubbles);
        end
        i_stall = 0;
    endtask

    task automatic test_random();
        logic [5:0] functs [12];
        functs = '{6'b100100, 6'b100101, 6'b100000, 6'b100001, 6'b000011, 6'b000010,
                   6'b100111, 6'b100010, 6'b100011, 6'b100110, 6'b000000, 6'b101010};
        for (int c = 0; c < 300; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_rs_data = 8'($urandom); i_rt_data = 8'($urandom); i_imm = 8'($urandom);
            i_shamt = 5'($urandom); i_rd_addr = 5'($urandom);
            i_rs_addr = 5'($urandom_range(0, 3)); i_rt_addr = 5'($urandom_range(0, 3));
            i_alu_op = 2'($urandom);
            i_funct = ($urandom_range(0, 4) == 0) ? 6'($urandom) : functs[$urandom_range(0, 11)];
            i_alu_src = 1'($urandom); i_reg_write = 1'($urandom);
            i_hold = ($urandom_range(0, 7) == 0);
            i_stall = ($urandom_range(0, 7) == 0);
            i_flush = ($urandom_range(0, 9) == 0);
            i_exmem_we = 1'($urandom); i_exmem_rd = 5'($urandom_range(0, 3));
            i_exmem_data = 8'($urandom);
            i_memwb_we = 1'($urandom); i_memwb_rd = 5'($urandom_range(0, 3));
            i_memwb_data = 8'($urandom);
            tick();
            n_cmp++;
            if (o_valid !== m_valid || o_reg_write !== m_rw || o_illegal !== m_ill) begin
                n_err++;
                $display("FAIL rnd_flags cyc %0d got v/rw/ill=%0b%0b%0b expected %0b%0b%0b",
                         c, o_valid, o_reg_write, o_illegal, m_valid, m_rw, m_ill);
            end
            n_cmp++;
            if (o_A !== m_a || o_B !== m_b) begin
                n_err++;
                $display("FAIL rnd_operands cyc %0d got A=%h B=%h expected A=%h B=%h",
                         c, o_A, o_B, m_a, m_b);
            end
            n_cmp++;
            if (o_select !== m_sel || o_rd_addr !== m_rd) begin
                n_err++;
                $display("FAIL rnd_sel_rd cyc %0d got sel=%b rd=%0d expected sel=%b rd=%0d",
                         c, o_select, o_rd_addr, m_sel, m_rd);
            end
            n_cmp++;
            if (o_bubbles !== 16'(m_bub) || s_bubbles !== 2'(m_bub_s)) begin
                n_err++;
                $display("FAIL rnd_bubbles cyc %0d got %0d/%0d expected %0d/%0d",
                         c, o_bubbles, s_bubbles, m_bub, m_bub_s);
            end
        end
    endtask

    task automatic test_reset_mid();
        idle();
        i_valid = 1; i_reg_write = 1; i_alu_op = 2'b11; i_rs_data = 8'h5A; i_rd_addr = 5'd3;
        i_alu_src = 1; i_imm = 8'hC3;
        tick();
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if ({o_valid, o_A, o_B, o_rd_addr, o_reg_write, o_illegal} !== 24'h0 ||
            o_select !== 4'b0111 || o_bubbles !== 16'd0 || s_bubbles !== 2'd0) begin
            n_err++;
            $display("FAIL reset_mid got v=%0b A=%h B=%h sel=%b rw=%0b bub=%0d expected cleared",
                     o_valid, o_A, o_B, o_select, o_reg_write, o_bubbles);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        n_cmp++;
        if (o_A !== 8'h5A || o_B !== 8'hC3 || o_select !== 4'b0001 || o_valid !== 1'b1) begin
            n_err++;
            $display("FAIL after_reset_ori got A=%h B=%h sel=%b v=%0b expected 5A C3 0001 1",
                     o_A, o_B, o_select, o_valid);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_load();
        test_forward();
        test_shift();
        test_priority();
        test_illegal();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
